// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and
// the per-state stage reset pattern.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD,
    S_MEM,
    S_PERIPH,
    S_RUN,
    S_SOFT
  } state_t;

  typedef enum logic [1:0] {
    RST_CAUSE_NONE = 2'b00,
    RST_CAUSE_POR  = 2'b01,
    RST_CAUSE_SOFT = 2'b10
  } cause_t;

  typedef struct packed {
    logic mem;
    logic periph;
    logic core;
  } stage_rst_t;

  // Active-low stage resets driven in each state.
  function automatic stage_rst_t stage_outs(input state_t s);
    stage_rst_t r;
    r = '0;
    case (s)
      S_HOLD:   r = 3'b000;
      S_MEM:    r = 3'b100;
      S_PERIPH: r = 3'b110;
      S_RUN:    r = 3'b111;
      S_SOFT:   r = 3'b100;
      default:  r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rst_seq.sv
// Reset sequencer: releases memory, peripheral and core resets in order with
// programmable gaps, and re-resets peripherals/core on a soft-reset request.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned STAGE_DLY = 16,
  parameter int unsigned SOFT_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst_req,
  input  logic       hold_core,
  output logic       mem_rst_n,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       rst_busy,
  output logic [1:0] rst_cause
);

  localparam int unsigned MAX_DLY = (STAGE_DLY > SOFT_HOLD) ? STAGE_DLY : SOFT_HOLD;
  localparam int unsigned CNT_W   = $clog2(MAX_DLY) + 1;
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_HOLD - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             soft_take;
  stage_rst_t       stage_q;
  logic             busy_q;
  cause_t           cause_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    soft_take = 1'b0;
    case (state)
      S_HOLD: begin
        if (cnt == STAGE_LAST) begin
          state_nxt = S_MEM;
          cnt_nxt   = '0;
        end
      end
      S_MEM: begin
        if (cnt == STAGE_LAST) begin
          state_nxt = S_PERIPH;
          cnt_nxt   = '0;
        end
      end
      S_PERIPH: begin
        // Counter parks at its terminal value while the core is held.
        if (cnt == STAGE_LAST) begin
          if (!hold_core) begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt;
          end
        end
      end
      S_RUN: begin
        cnt_nxt = '0;
        if (soft_rst_req) begin
          state_nxt = S_SOFT;
          soft_take = 1'b1;
        end
      end
      S_SOFT: begin
        if (cnt == SOFT_LAST) begin
          state_nxt = S_MEM;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_HOLD;
      cnt     <= '0;
      stage_q <= '0;
      busy_q  <= 1'b1;
      cause_q <= RST_CAUSE_POR;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      stage_q <= stage_outs(state_nxt);
      busy_q  <= (state_nxt != S_RUN);
      if (soft_take) cause_q <= RST_CAUSE_SOFT;
    end
  end

  assign mem_rst_n    = stage_q.mem;
  assign periph_rst_n = stage_q.periph;
  assign core_rst_n   = stage_q.core;
  assign rst_busy     = busy_q;
  assign rst_cause    = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: expected output vectors are queued with the
// edge they must appear after and compared as the DUT reaches that edge.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       hold_core = 1'b0;
  logic       mem_rst_n, periph_rst_n, core_rst_n, rst_busy;
  logic [1:0] rst_cause;

  rst_seq #(.STAGE_DLY(4), .SOFT_HOLD(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_rst_req),
    .hold_core    (hold_core),
    .mem_rst_n    (mem_rst_n),
    .periph_rst_n (periph_rst_n),
    .core_rst_n   (core_rst_n),
    .rst_busy     (rst_busy),
    .rst_cause    (rst_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    string       tag;
    logic [5:0]  val;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %b want %b", tag, cyc, obs, exp);
    end
  endtask

  // val = {mem, periph, core, busy, cause[1:0]}
  task automatic push(input int unsigned at, input string tag,
                      input logic m, input logic p, input logic c,
                      input logic b, input logic [1:0] cause);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.val = {m, p, c, b, cause};
    sb.push_back(e);
  endtask

  task automatic run_to(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    chk("order", {5'b0, (core_rst_n & ~periph_rst_n) | (periph_rst_n & ~mem_rst_n)}, 6'b0);
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, {mem_rst_n, periph_rst_n, core_rst_n, rst_busy, rst_cause}, mon_e.val);
    end
  end

  int unsigned base, s0, h;

  initial begin
    // Power-on: 5 edges with rst_n low, then the normal release ladder.
    repeat (4) @(negedge clk);
    push(cyc + 1, "por_hold", 0, 0, 0, 1, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    push(base + 3,  "por_mem_pre",    0, 0, 0, 1, 2'b01);
    push(base + 4,  "por_mem_up",     1, 0, 0, 1, 2'b01);
    push(base + 7,  "por_periph_pre", 1, 0, 0, 1, 2'b01);
    push(base + 8,  "por_periph_up",  1, 1, 0, 1, 2'b01);
    push(base + 11, "por_core_pre",   1, 1, 0, 1, 2'b01);
    push(base + 12, "por_core_up",    1, 1, 1, 0, 2'b01);
    run_to(base + 12);

    // One-cycle soft request accepted at edge s0.
    @(negedge clk);
    soft_rst_req = 1'b1;
    s0 = cyc + 1;
    push(s0, "soft_drop", 1, 0, 0, 1, 2'b10);
    @(negedge clk);
    soft_rst_req = 1'b0;
    push(s0 + 4,  "soft_mid",        1, 0, 0, 1, 2'b10);
    push(s0 + 8,  "soft_mem_stage",  1, 0, 0, 1, 2'b10);
    push(s0 + 11, "soft_periph_pre", 1, 0, 0, 1, 2'b10);
    push(s0 + 12, "soft_periph_up",  1, 1, 0, 1, 2'b10);
    push(s0 + 15, "soft_core_pre",   1, 1, 0, 1, 2'b10);
    push(s0 + 16, "soft_core_up",    1, 1, 1, 0, 2'b10);
    run_to(s0 + 16);

    // Halt-at-reset: core stays in reset until hold_core drops.
    @(negedge clk);
    rst_n = 1'b0;
    hold_core = 1'b1;
    push(cyc + 1, "halt_rst", 0, 0, 0, 1, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    push(base + 8,  "halt_periph_up", 1, 1, 0, 1, 2'b01);
    push(base + 30, "halt_still",     1, 1, 0, 1, 2'b01);
    run_to(base + 30);
    hold_core = 1'b0;
    h = cyc + 1;
    push(h, "halt_release", 1, 1, 1, 0, 2'b01);
    run_to(h);

    // Reset pulse at edge 6 of a power-on sequence.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    push(base + 4, "mid_mem_up", 1, 0, 0, 1, 2'b01);
    run_to(base + 5);
    rst_n = 1'b0;
    push(base + 6, "mid_rst", 0, 0, 0, 1, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    push(base + 3,  "mid_mem_pre",  0, 0, 0, 1, 2'b01);
    push(base + 4,  "mid_mem_up2",  1, 0, 0, 1, 2'b01);
    push(base + 12, "mid_core_up",  1, 1, 1, 0, 2'b01);
    run_to(base + 12);

    // Reset pulse in the middle of a soft reset.
    @(negedge clk);
    soft_rst_req = 1'b1;
    s0 = cyc + 1;
    push(s0, "msoft_drop", 1, 0, 0, 1, 2'b10);
    @(negedge clk);
    soft_rst_req = 1'b0;
    run_to(s0 + 3);
    rst_n = 1'b0;
    push(s0 + 4, "msoft_rst", 0, 0, 0, 1, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    push(base + 4,  "msoft_mem_up",  1, 0, 0, 1, 2'b01);
    push(base + 12, "msoft_core_up", 1, 1, 1, 0, 2'b01);
    run_to(base + 12);

    // Request held from S_MEM onwards: ignored until the first S_RUN edge.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    run_to(base + 5);
    soft_rst_req = 1'b1;
    push(base + 8,  "ign_periph_up", 1, 1, 0, 1, 2'b01);
    push(base + 12, "ign_run",       1, 1, 1, 0, 2'b01);
    push(base + 13, "ign_soft",      1, 0, 0, 1, 2'b10);
    run_to(base + 13);
    soft_rst_req = 1'b0;
    push(base + 29, "ign_soft_done", 1, 1, 1, 0, 2'b10);
    run_to(base + 29);

    // rst_n low together with a soft request: hard reset wins.
    @(negedge clk);
    rst_n = 1'b0;
    soft_rst_req = 1'b1;
    push(cyc + 1, "simul_rst", 0, 0, 0, 1, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    soft_rst_req = 1'b0;
    base = cyc;
    push(base + 12, "simul_core_up", 1, 1, 1, 0, 2'b01);
    run_to(base + 12);

    @(negedge clk);
    chk("sb_drained", 6'(sb.size()), 6'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
